// File: rtl/gated_event_counter_if.sv
// Bundles the gate input, controls and the counter status outputs.
// The master drives s/enable/clear; the slave (counter) returns the status.
interface gated_event_counter_if #(
    parameter int WIDTH = 8
);
    logic             s;
    logic             enable;
    logic             clear;
    logic [WIDTH-1:0] count;
    logic             pulse;
    logic             overflow;
    logic [1:0]       state;

    modport master (
        output s, enable, clear,
        input  count, pulse, overflow, state
    );

    modport slave (
        input  s, enable, clear,
        output count, pulse, overflow, state
    );
endinterface

// File: rtl/gated_event_counter.sv
// Debounces the gate level s and counts each qualified high period once.
// Provides a saturating count, a one-cycle event pulse and a sticky overflow flag.
//
//  state | meaning
//  ------+------------------------------------------------------------
//  IDLE  | waiting for s high with enable
//  QUAL  | s has been high for stab consecutive samples, not yet STABLE
//  HELD  | event issued; waiting for s low before another can start
module gated_event_counter #(
    parameter int WIDTH  = 8,
    parameter int STABLE = 3
) (
    input  logic                 clk_i,
    input  logic                 reset_i,
    gated_event_counter_if.slave bus
);
    typedef enum logic [1:0] {
        IDLE = 2'b00,
        QUAL = 2'b01,
        HELD = 2'b10
    } state_t;

    localparam logic [7:0]       STAB_LAST = 8'(STABLE - 1);
    localparam logic [WIDTH-1:0] CNT_MAX   = '1;

    state_t           state_q, state_d;
    logic [7:0]       stab_q, stab_d;
    logic [WIDTH-1:0] count_q, count_d;
    logic             pulse_q, pulse_d;
    logic             ovf_q, ovf_d;
    logic             event_d;

    // Register FSM, stability counter and all outputs; reset wins over everything.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q <= IDLE;
            stab_q  <= 8'd0;
            count_q <= '0;
            pulse_q <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            stab_q  <= stab_d;
            count_q <= count_d;
            pulse_q <= pulse_d;
            ovf_q   <= ovf_d;
        end
    end

    // Next state and stability count; flags an event when qualification completes.
    always_comb begin
        state_d = state_q;
        stab_d  = stab_q;
        event_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.s && bus.enable) begin
                    if (STABLE == 1) begin
                        state_d = HELD;
                        stab_d  = 8'd0;
                        event_d = 1'b1;
                    end else begin
                        state_d = QUAL;
                        stab_d  = 8'd1;
                    end
                end
            end
            QUAL: begin
                if (!bus.s || !bus.enable) begin
                    state_d = IDLE;
                    stab_d  = 8'd0;
                end else if (stab_q == STAB_LAST) begin
                    state_d = HELD;
                    stab_d  = 8'd0;
                    event_d = 1'b1;
                end else begin
                    stab_d = stab_q + 8'd1;
                end
            end
            HELD: begin
                // enable is deliberately ignored here: only s low re-arms.
                if (!bus.s) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
                stab_d  = 8'd0;
            end
        endcase
    end

    // Next output values: clear resets the count but still lets a coincident event register as 1.
    always_comb begin
        count_d = count_q;
        ovf_d   = ovf_q;
        pulse_d = event_d;
        if (bus.clear) begin
            count_d = event_d ? WIDTH'(1) : '0;
            ovf_d   = 1'b0;
        end else if (event_d) begin
            if (count_q == CNT_MAX) begin
                ovf_d = 1'b1;
            end else begin
                count_d = count_q + WIDTH'(1);
            end
        end
    end

    assign bus.count    = count_q;
    assign bus.pulse    = pulse_q;
    assign bus.overflow = ovf_q;
    assign bus.state    = state_q;
endmodule

// File: tb/tb_gated_event_counter.sv
// Scoreboard bench for gated_event_counter (WIDTH=4, STABLE=3).
// Each driven cycle pushes the expected post-edge outputs; they are popped and
// compared one time unit after the edge, alongside a few directed checks.
module tb_gated_event_counter;
    localparam int W    = 4;
    localparam int ST   = 3;
    localparam int MAXC = (1 << W) - 1;

    typedef struct {
        int cnt;
        int pul;
        int ovf;
        int st;
    } exp_t;

    logic clk_i = 1'b0;
    logic reset_i = 1'b1;
    int   total = 0;
    int   bad = 0;
    exp_t sb[$];

    // reference model state
    int m_st = 0, m_run = 0, m_cnt = 0, m_ovf = 0, m_pul = 0;

    gated_event_counter_if #(.WIDTH(W)) bus ();

    gated_event_counter #(.WIDTH(W), .STABLE(ST)) dut (
        .clk_i  (clk_i),
        .reset_i(reset_i),
        .bus    (bus.slave)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input int obs, input int exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Drive one cycle of stimulus, predict the outcome, then compare after the edge.
    task automatic step(input logic sv, input logic ev, input logic cv, input logic rv = 1'b0);
        exp_t e;
        int   evt;
        bus.s      = sv;
        bus.enable = ev;
        bus.clear  = cv;
        reset_i    = rv;
        evt = 0;
        if (rv) begin
            m_st = 0; m_run = 0; m_cnt = 0; m_ovf = 0; m_pul = 0;
        end else begin
            if (m_st == 0) begin
                if (sv && ev) begin
                    m_run = 1;
                    if (m_run >= ST) begin evt = 1; m_st = 2; end
                    else m_st = 1;
                end
            end else if (m_st == 1) begin
                if (!sv || !ev) begin m_st = 0; m_run = 0; end
                else begin
                    m_run++;
                    if (m_run >= ST) begin evt = 1; m_st = 2; end
                end
            end else begin
                if (!sv) begin m_st = 0; m_run = 0; end
            end
            if (cv) begin
                m_cnt = evt; m_ovf = 0;
            end else if (evt != 0) begin
                if (m_cnt == MAXC) m_ovf = 1;
                else m_cnt++;
            end
            m_pul = evt;
        end
        e.cnt = m_cnt; e.pul = m_pul; e.ovf = m_ovf; e.st = m_st;
        sb.push_back(e);
        @(posedge clk_i);
        #1;
        e = sb.pop_front();
        chk("count", int'(bus.count), e.cnt);
        chk("pulse", int'(bus.pulse), e.pul);
        chk("overflow", int'(bus.overflow), e.ovf);
        chk("state", int'(bus.state), e.st);
    endtask

    task automatic one_event();
        for (int i = 0; i < ST; i++) step(1'b1, 1'b1, 1'b0);
        step(1'b0, 1'b1, 1'b0);
    endtask

    initial begin
        int t2_st[6]  = '{1, 1, 2, 2, 2, 0};
        int t2_pul[6] = '{0, 0, 1, 0, 0, 0};
        int t2_cnt[6] = '{0, 0, 1, 1, 1, 1};
        int glitch[6] = '{1, 1, 0, 1, 1, 0};

        bus.s = 1'b1; bus.enable = 1'b1; bus.clear = 1'b0;

        // T1 reset held with s/enable high
        step(1'b1, 1'b1, 1'b0, 1'b1);
        step(1'b1, 1'b1, 1'b0, 1'b1);
        chk("t1_count", int'(bus.count), 0);
        chk("t1_pulse", int'(bus.pulse), 0);
        chk("t1_ovf", int'(bus.overflow), 0);
        chk("t1_state", int'(bus.state), 0);
        step(1'b1, 1'b1, 1'b0);
        chk("t1_qual_first_edge", int'(bus.state), 1);
        step(1'b0, 1'b1, 1'b0);

        // T2 qualify: five high samples then low
        for (int i = 0; i < 6; i++) begin
            step(i < 5, 1'b1, 1'b0);
            chk("t2_state", int'(bus.state), t2_st[i]);
            chk("t2_pulse", int'(bus.pulse), t2_pul[i]);
            chk("t2_count", int'(bus.count), t2_cnt[i]);
        end

        // T3 glitch reject
        for (int i = 0; i < 6; i++) begin
            step(glitch[i] != 0, 1'b1, 1'b0);
            chk("t3_no_held", int'(bus.state == 2'b10), 0);
            chk("t3_no_pulse", int'(bus.pulse), 0);
        end
        chk("t3_count", int'(bus.count), 1);

        // T4 enable low blocks, drop in QUAL aborts, drop in HELD ignored
        for (int i = 0; i < 6; i++) step(1'b1, 1'b0, 1'b0);
        chk("t4_dis_state", int'(bus.state), 0);
        step(1'b0, 1'b1, 1'b0);
        step(1'b1, 1'b1, 1'b0);
        step(1'b1, 1'b0, 1'b0);
        chk("t4_qual_drop", int'(bus.state), 0);
        step(1'b0, 1'b1, 1'b0);
        for (int i = 0; i < ST; i++) step(1'b1, 1'b1, 1'b0);
        step(1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0);
        chk("t4_held_drop", int'(bus.state), 2);
        step(1'b0, 1'b0, 1'b0);
        chk("t4_held_exit", int'(bus.state), 0);
        chk("t4_count", int'(bus.count), 2);

        // reset mid-qualification discards progress
        step(1'b1, 1'b1, 1'b0);
        step(1'b1, 1'b1, 1'b0);
        step(1'b1, 1'b1, 1'b0, 1'b1);
        step(1'b1, 1'b1, 1'b0);
        step(1'b1, 1'b1, 1'b0);
        chk("rst_mid_no_pulse", int'(bus.pulse), 0);
        step(1'b1, 1'b1, 1'b0);
        chk("rst_mid_pulse", int'(bus.pulse), 1);
        step(1'b0, 1'b1, 1'b0);

        // T5 saturation
        step(1'b0, 1'b1, 1'b1);
        for (int k = 1; k <= 16; k++) begin
            for (int i = 0; i < ST; i++) step(1'b1, 1'b1, 1'b0);
            if (k == 15) chk("t5_count15", int'(bus.count), 15);
            if (k == 16) begin
                chk("t5_pulse16", int'(bus.pulse), 1);
                chk("t5_count16", int'(bus.count), 15);
                chk("t5_ovf16", int'(bus.overflow), 1);
            end
            step(1'b0, 1'b1, 1'b0);
        end
        step(1'b0, 1'b1, 1'b1);
        chk("t5_clr_count", int'(bus.count), 0);
        chk("t5_clr_ovf", int'(bus.overflow), 0);

        // T6 clear colliding with an event at count=7
        for (int k = 0; k < 7; k++) one_event();
        chk("t6_pre_count", int'(bus.count), 7);
        step(1'b1, 1'b1, 1'b0);
        step(1'b1, 1'b1, 1'b0);
        step(1'b1, 1'b1, 1'b1);
        chk("t6_count", int'(bus.count), 1);
        chk("t6_ovf", int'(bus.overflow), 0);
        chk("t6_pulse", int'(bus.pulse), 1);
        step(1'b1, 1'b1, 1'b0);
        chk("t6_pulse_once", int'(bus.pulse), 0);
        step(1'b0, 1'b1, 1'b0);

        chk("sb_drained", sb.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
